// File: rtl/operand_issue_stage.sv
// Operand issue stage: per-operand forwarding mux + immediate/register select, held in a 2-entry elastic buffer.
// Latency: one cycle from accept to out_valid; one set per cycle sustained while out_ready is high.
// Backpressure: in_ready = !skid_valid (registered only); one stalled cycle is absorbed by the skid register.
//
// Ports:
//   clk, rst_n, flush          clock, async active-low reset, synchronous flush
//   in_valid/in_ready          upstream handshake for one operand set
//   immediate, operandA/B      immediate and register-file read values
//   sourceSelect               [1] A-side uses register (else imm), [0] B-side uses register (else imm)
//   fwdSelA/B, fwdData         0 = register file, k in 1..NUM_FWD = fwdData slice k-1, larger = register file
//   out_valid/out_ready        downstream (ALU) handshake
//   resultA/B                  registered selected operands
//   occupancy                  number of entries held (0..2)
module operand_issue_stage #(
  parameter int WIDTH   = 32,
  parameter int NUM_FWD = 2,
  localparam int FSW    = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         immediate,
  input  logic [WIDTH-1:0]         operandA,
  input  logic [WIDTH-1:0]         operandB,
  input  logic [1:0]               sourceSelect,
  input  logic [FSW-1:0]           fwdSelA,
  input  logic [FSW-1:0]           fwdSelB,
  input  logic [NUM_FWD*WIDTH-1:0] fwdData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         resultA,
  output logic [WIDTH-1:0]         resultB,
  output logic [1:0]               occupancy
);

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] out_a, out_b;
  logic [WIDTH-1:0] skid_a, skid_b;
  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             accept, consume;

  // Forwarding mux: unmatched select codes (0 or out of range) fall back to the register value.
  always_comb begin
    fwd_a = operandA;
    fwd_b = operandB;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (fwdSelA == FSW'(k)) fwd_a = fwdData[(k-1)*WIDTH +: WIDTH];
      if (fwdSelB == FSW'(k)) fwd_b = fwdData[(k-1)*WIDTH +: WIDTH];
    end
  end

  // Immediate path bypasses forwarding entirely.
  assign sel_a = sourceSelect[1] ? fwd_a : immediate;
  assign sel_b = sourceSelect[0] ? fwd_b : immediate;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign resultA   = out_a;
  assign resultB   = out_b;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_a  <= '0;
      out_b  <= '0;
      skid_a <= '0;
      skid_b <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only validity is dropped.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_a <= sel_a;
            out_b <= sel_b;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_a <= sel_a;
            out_b <= sel_b;
          end else if (accept) begin
            skid_a <= sel_a;
            skid_b <= sel_b;
            state  <= FULL;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            out_a <= skid_a;
            out_b <= skid_b;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Testbench for operand_issue_stage: directed steps from the test plan, then randomized traffic.
// Reference: a queue of expected operand pairs; occupancy, valid and ready all follow from its length.
// Inputs change 1 time unit after each rising edge; outputs are compared there as well.
module tb_operand_issue_stage;

  localparam int WIDTH   = 32;
  localparam int NUM_FWD = 2;
  localparam int FSW     = $clog2(NUM_FWD + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         immediate;
  logic [WIDTH-1:0]         operandA;
  logic [WIDTH-1:0]         operandB;
  logic [1:0]               sourceSelect;
  logic [FSW-1:0]           fwdSelA;
  logic [FSW-1:0]           fwdSelB;
  logic [NUM_FWD*WIDTH-1:0] fwdData;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         resultA;
  logic [WIDTH-1:0]         resultB;
  logic [1:0]               occupancy;

  logic [WIDTH-1:0] f0, f1;
  assign fwdData = {f1, f0};

  operand_issue_stage #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .immediate(immediate), .operandA(operandA), .operandB(operandB),
    .sourceSelect(sourceSelect), .fwdSelA(fwdSelA), .fwdSelB(fwdSelB),
    .fwdData(fwdData),
    .out_valid(out_valid), .out_ready(out_ready),
    .resultA(resultA), .resultB(resultB), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  pair_t            mq[$];     // entries the stage should be holding, oldest first
  logic [WIDTH-1:0] seen[$];   // resultA values actually handed to the ALU
  int               errors = 0;
  int               checks = 0;
  int               max_occ;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Operand value for one side, straight from the selection rules.
  function automatic logic [WIDTH-1:0] pick(input logic use_reg, input logic [FSW-1:0] fsel,
                                            input logic [WIDTH-1:0] regv);
    logic [WIDTH-1:0] f[NUM_FWD];
    f[0] = f0;
    f[1] = f1;
    if (!use_reg) return immediate;
    if (fsel >= 1 && int'(fsel) <= NUM_FWD) return f[int'(fsel) - 1];
    return regv;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".occ"},   {30'd0, occupancy}, WIDTH'(mq.size()));
    chk({tag, ".ovld"},  {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk({tag, ".irdy"},  {31'd0, in_ready},  {31'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      chk({tag, ".resA"}, resultA, mq[0].a);
      chk({tag, ".resB"}, resultB, mq[0].b);
    end
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  // One clock with the currently driven inputs; model advances at the edge.
  task automatic do_cycle(input string tag, output bit acc);
    bit    con;
    pair_t p;
    acc   = in_valid && (mq.size() < 2);
    con   = out_ready && (mq.size() > 0);
    p.a   = pick(sourceSelect[1], fwdSelA, operandA);
    p.b   = pick(sourceSelect[0], fwdSelB, operandB);
    if (out_valid && out_ready) seen.push_back(resultA);
    @(posedge clk);
    if (con) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (acc) mq.push_back(p);
    #1;
    check_state(tag);
  endtask

  task automatic set_in(input logic v, input logic [1:0] ss, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [FSW-1:0] sa, input logic [FSW-1:0] sb);
    in_valid     = v;
    sourceSelect = ss;
    operandA     = a;
    operandB     = b;
    fwdSelA      = sa;
    fwdSelB      = sb;
  endtask

  initial begin
    bit acc;
    int n;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    immediate = 32'hDEAD_BEEF; f0 = '0; f1 = '0;
    set_in(1'b0, 2'b11, '0, '0, '0, '0);
    max_occ = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_state("reset");
    chk("reset.resA", resultA, 32'h0);
    chk("reset.resB", resultB, 32'h0);

    // First transfer: one-cycle latency
    set_in(1'b1, 2'b11, 32'h11, 32'h22, 2'd0, 2'd0);
    do_cycle("first", acc);
    chk("first.resA", resultA, 32'h11);
    chk("first.resB", resultB, 32'h22);
    chk("first.occ", {30'd0, occupancy}, 32'd1);

    // All four source-select codes back to back
    set_in(1'b1, 2'b00, 32'd1, 32'd2, 2'd0, 2'd0);
    do_cycle("ss00", acc);
    chk("ss00.pair", {resultA[15:0], resultB[15:0]}, 32'hBEEF_BEEF);
    sourceSelect = 2'b01;
    do_cycle("ss01", acc);
    chk("ss01.B", resultB, 32'd2);
    sourceSelect = 2'b10;
    do_cycle("ss10", acc);
    chk("ss10.A", resultA, 32'd1);
    chk("ss10.B", resultB, 32'hDEAD_BEEF);
    sourceSelect = 2'b11;
    do_cycle("ss11", acc);
    chk("ss11.B", resultB, 32'd2);

    // Forwarding, out-of-range select, immediate not forwarded
    f0 = 32'hAAAA; f1 = 32'hBBBB;
    set_in(1'b1, 2'b11, 32'h5, 32'h6, 2'd2, 2'd1);
    do_cycle("fwd", acc);
    chk("fwd.A", resultA, 32'hBBBB);
    chk("fwd.B", resultB, 32'hAAAA);
    fwdSelA = 2'd3;
    do_cycle("fwd_oor", acc);
    chk("fwd_oor.A", resultA, 32'h5);
    fwdSelA = 2'd2; sourceSelect = 2'b01;
    do_cycle("fwd_imm", acc);
    chk("fwd_imm.A", resultA, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    do_cycle("drain0", acc);

    // Stream 1..5 with a two-cycle stall
    seen.delete(); max_occ = 0; n = 1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      set_in(n <= 5, 2'b11, WIDTH'(n), WIDTH'(n + 100), 2'd0, 2'd0);
      out_ready = !(cyc == 2 || cyc == 3);
      do_cycle("stream", acc);
      if (acc) n++;
    end
    chk("stream.maxocc", WIDTH'(max_occ), 32'd2);
    chk("stream.count", WIDTH'(seen.size()), 32'd5);
    for (int i = 0; i < seen.size() && i < 5; i++) chk("stream.order", seen[i], WIDTH'(i + 1));

    // Fill to FULL, then flush with an input offered
    out_ready = 1'b0;
    set_in(1'b1, 2'b11, 32'h100, 32'h0, 2'd0, 2'd0);
    do_cycle("fill1", acc);
    operandA = 32'h200;
    do_cycle("fill2", acc);
    chk("fill.occ", {30'd0, occupancy}, 32'd2);
    flush = 1'b1; operandA = 32'h300;
    do_cycle("flush", acc);
    chk("flush.occ", {30'd0, occupancy}, 32'd0);
    chk("flush.irdy", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; seen.delete();
    repeat (3) do_cycle("post_flush", acc);
    chk("flush.nothing_out", WIDTH'(seen.size()), 32'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    set_in(1'b1, 2'b11, 32'h400, 32'h401, 2'd0, 2'd0);
    do_cycle("rfill1", acc);
    do_cycle("rfill2", acc);
    #3 rst_n = 1'b0;
    #1;
    mq.delete();
    check_state("async_rst");
    chk("async_rst.resA", resultA, 32'h0);
    #2 rst_n = 1'b1;
    set_in(1'b1, 2'b11, 32'h55, 32'h66, 2'd0, 2'd0);
    out_ready = 1'b1;
    do_cycle("post_rst", acc);
    chk("post_rst.A", resultA, 32'h55);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      f0 = $urandom; f1 = $urandom; immediate = $urandom;
      set_in(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom,
             2'($urandom), 2'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      do_cycle("rand", acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Registered, parametrised operand-selection stage between register read and the ALU. Per operand, it chooses between the register-file value and one of NUM_FWD forwarding buses, then applies the immediate/register source select. The results are held in a two-entry elastic buffer (output register plus skid register) with valid/ready handshaking on both sides. This lets the ALU stall without combinational ready paths back into decode.

## Interface
- WIDTH, 32, datapath width in bits.
- NUM_FWD, 2, number of forwarding buses (≥1); FSW = $clog2(NUM_FWD+1).

- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream presents an operand set.
- in_ready  output  1  stage can accept this cycle.
- immediate  input  WIDTH  immediate from the instruction.
- operandA, operandB  input  WIDTH  register-file read values.
- sourceSelect  input  2  00 imm/imm, 01 imm/B, 10 A/imm, 11 A/B (A-side/B-side).
- fwdSelA, fwdSelB  input  FSW  0 selects the register file; k in 1..NUM_FWD selects fwdData slice k-1.
- fwdData  input  NUM_FWD*WIDTH  forwarding buses; slice k-1 is bits [k*WIDTH-1:(k-1)*WIDTH].
- out_valid  output  1  resultA/resultB hold a valid set.
- out_ready  input  1  ALU consumes this cycle.
- resultA, resultB  output  WIDTH  selected operands, registered.
- occupancy  output  2  entries held: 0, 1 or 2.

## Operation
- Accept: in_valid && in_ready. Consume: out_valid && out_ready.
- Forward step, per operand: fwdSel = 0 passes the register value. 1..NUM_FWD passes the matching fwdData slice. Any value > NUM_FWD passes the register value.
- Select step: sourceSelect routes the immediate or the forwarded register operand onto each side, using the encoding above. Forwarding never alters the immediate.
- Values are computed combinationally at accept time and captured, so later fwdData changes do not affect stored entries.
- Storage: out register (drives resultA/resultB/out_valid) and skid register.
- in_ready = !skid_valid. It is a registered-state function only and never depends on out_ready combinationally.
- States, by occupancy:
  - EMPTY(0)
    - accept → ONE, new set into out register.
  - ONE(1)
    - accept && consume → ONE, out register loaded with new set.
    - accept only → FULL, new set into skid register.
    - consume only → EMPTY.
  - FULL(2)
    - No accept possible (in_ready = 0).
    - consume → ONE, skid moves to out register, skid cleared.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated.
- Flush: both entries are invalidated at the next edge and occupancy becomes 0. An input accepted in the flush cycle is discarded. A consume in the flush cycle is legal, and the ALU takes the current out value.
- Data registers need not be cleared by flush. When out_valid = 0, resultA and resultB are don't-care but must be stable.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, occupancy = 0, in_ready = 1, resultA = 0, resultB = 0, skid data = 0.
- Latency: accept at edge N makes out_valid = 1 with data after edge N, which is one cycle.
- Throughput: one set per cycle while out_ready stays high.
- A single-cycle stall (out_ready low) absorbs exactly one extra set. in_ready drops the cycle after the skid fills and returns the cycle after the skid drains.
- Reset asserted mid-transfer clears all state immediately. After rst_n deasserts, the first accept may occur at the first rising edge.
- flush and rst_n together: reset dominates.

## Test plan
- Reset, then send sourceSelect = 11, operandA = 0x11, operandB = 0x22, fwdSel = 0, with out_ready = 1 -> next cycle out_valid = 1, resultA = 0x11, resultB = 0x22, occupancy = 1.
- All four sourceSelect codes with immediate = 0xDEAD_BEEF, A = 1, B = 2 -> the pairs (imm,imm), (imm,2), (1,imm), (1,2) appear on consecutive cycles.
- Set fwdSelA = 2 and fwdSelB = 1, with slice0 = 0xAAAA and slice1 = 0xBBBB, sourceSelect = 11 -> resultA = 0xBBBB, resultB = 0xAAAA. Then set fwdSelA = 3 (out of range) -> resultA = operandA. Then set fwdSelA = 2 with sourceSelect = 01 -> resultA = immediate.
- Stream sets 1..5 with in_valid held high and out_ready low on cycles 2-3 -> occupancy reaches 2, in_ready = 0 for exactly the FULL cycles, and the ALU sees 1..5 in order with no loss or duplication.
- Fill to FULL, then assert flush with in_valid = 1 -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, and the flushed input never appears.
- Drop rst_n asynchronously while FULL (between clock edges) -> out_valid = 0, occupancy = 0 and in_ready = 1 immediately, before the next edge. After release, a new set is accepted on the first edge.
